// File: rtl/spi_ram_pkg.sv
// Shared constants and state/phase encodings for the SPI RAM-access initiator.
package spi_ram_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h00;
  localparam logic [7:0] CMD_READ  = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_LOAD     = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_CS_HOLD  = 3'd4,
    ST_CS_GAP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PH_CMD   = 2'd0,
    PH_ADDR  = 2'd1,
    PH_DUMMY = 2'd2,
    PH_DATA  = 2'd3
  } phase_e;

endpackage

// File: rtl/spi_ram_master_clk_gen.sv
// SCLK divider: toggles SCLK every c_clk_div cycles while enabled and flags
// the cycle in which each rising/falling edge is about to happen.
module spi_clk_gen
  import spi_ram_pkg::*;
#(
  parameter int c_clk_div = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(c_clk_div + 1);

  logic [CW-1:0] cnt_r;
  logic          sclk_r;
  logic          wrap_s;

  // Edge strobes lead the SCLK register by one cycle so callers act on the edge itself.
  always_comb begin
    wrap_s = en && (cnt_r == CW'(c_clk_div - 1));
    rise   = wrap_s && !sclk_r;
    fall   = wrap_s && sclk_r;
  end

  // Half-period counter and SCLK level; clr parks SCLK low between bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r  <= {CW{1'b0}};
      sclk_r <= 1'b0;
    end else if (clr) begin
      cnt_r  <= {CW{1'b0}};
      sclk_r <= 1'b0;
    end else if (wrap_s) begin
      cnt_r  <= {CW{1'b0}};
      sclk_r <= ~sclk_r;
    end else if (en) begin
      cnt_r  <= cnt_r + CW'(1);
    end else begin
      cnt_r  <= cnt_r;
    end
  end

  assign sclk = sclk_r;

endmodule

// File: rtl/spi_ram_master.sv
// SPI mode-0 initiator for the cmd/address/dummy/data RAM-access protocol,
// bridging a byte-stream request interface to the four SPI pins.
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int c_addr_bits = 32,
  parameter int c_len_bits  = 16,
  parameter int c_clk_div   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   rd,
  input  logic [c_addr_bits-1:0] addr,
  input  logic [c_len_bits-1:0]  len,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   spi_csn,
  output logic                   spi_sclk,
  output logic                   spi_mosi,
  input  logic                   spi_miso
);

  localparam int TW           = $clog2(c_clk_div + 1);
  localparam int C_ADDR_BYTES = c_addr_bits / 8;
  localparam logic [c_len_bits-1:0] LEN_ZERO = {c_len_bits{1'b0}};
  localparam logic [c_len_bits-1:0] LEN_ONE  = c_len_bits'(1);

  state_e                 state_r;
  phase_e                 phase_r;
  phase_e                 next_phase_s;
  logic                   end_s;
  logic                   rd_r;
  logic [c_addr_bits-1:0] addr_r;
  logic [7:0]             addr_left_r;
  logic [c_len_bits-1:0]  len_r;
  logic [TW-1:0]          tmr_r;
  logic [2:0]             bit_cnt_r;
  logic [7:0]             sh_tx_r;
  logic [6:0]             sh_rx_r;
  logic [7:0]             load_byte_s;
  logic                   wait_write_s;
  logic                   last_bit_s;
  logic                   tmr_end_s;
  logic                   rise_s;
  logic                   fall_s;
  logic                   busy_r;
  logic                   done_r;
  logic                   csn_r;
  logic                   mosi_r;
  logic                   rx_valid_r;
  logic [7:0]             rx_data_r;

  spi_clk_gen #(
    .c_clk_div(c_clk_div)
  ) u_clk_gen (
    .clk   (clk),
    .reset (reset),
    .en    (state_r == ST_SHIFT),
    .clr   (state_r != ST_SHIFT),
    .sclk  (spi_sclk),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  // Byte to put on the wire for the current phase.
  always_comb begin
    load_byte_s = 8'h00;
    case (phase_r)
      PH_CMD:   load_byte_s = rd_r ? CMD_READ : CMD_WRITE;
      PH_ADDR:  load_byte_s = addr_r[c_addr_bits-1 -: 8];
      PH_DUMMY: load_byte_s = 8'h00;
      PH_DATA:  load_byte_s = rd_r ? 8'h00 : tx_data;
      default:  load_byte_s = 8'h00;
    endcase
  end

  // Phase sequencing decided at the end of each byte.
  always_comb begin
    next_phase_s = phase_r;
    end_s        = 1'b0;
    case (phase_r)
      PH_CMD: next_phase_s = PH_ADDR;
      PH_ADDR: begin
        if (addr_left_r != 8'd0) next_phase_s = PH_ADDR;
        else if (rd_r)           next_phase_s = PH_DUMMY;
        else if (len_r == LEN_ZERO) end_s     = 1'b1;
        else                     next_phase_s = PH_DATA;
      end
      PH_DUMMY: begin
        if (len_r == LEN_ZERO) end_s        = 1'b1;
        else                   next_phase_s = PH_DATA;
      end
      PH_DATA: begin
        if (len_r == LEN_ONE) end_s        = 1'b1;
        else                  next_phase_s = PH_DATA;
      end
      default: end_s = 1'b1;
    endcase
  end

  assign wait_write_s = (phase_r == PH_DATA) && !rd_r;
  assign last_bit_s   = (bit_cnt_r == 3'd7);
  assign tmr_end_s    = (tmr_r == TW'(c_clk_div - 1));

  // Transaction FSM, shift registers, counters and registered pin/handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      phase_r     <= PH_CMD;
      rd_r        <= 1'b0;
      addr_r      <= {c_addr_bits{1'b0}};
      addr_left_r <= 8'd0;
      len_r       <= LEN_ZERO;
      tmr_r       <= {TW{1'b0}};
      bit_cnt_r   <= 3'd0;
      sh_tx_r     <= 8'h00;
      sh_rx_r     <= 7'h00;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      csn_r       <= 1'b1;
      mosi_r      <= 1'b0;
      rx_valid_r  <= 1'b0;
      rx_data_r   <= 8'h00;
    end else begin
      done_r     <= 1'b0;
      rx_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r     <= ST_CS_SETUP;
            phase_r     <= PH_CMD;
            rd_r        <= rd;
            addr_r      <= addr;
            len_r       <= len;
            addr_left_r <= 8'(C_ADDR_BYTES - 1);
            tmr_r       <= {TW{1'b0}};
            busy_r      <= 1'b1;
            csn_r       <= 1'b0;
            mosi_r      <= 1'b0;
          end
        end
        ST_CS_SETUP: begin
          if (tmr_end_s) begin
            tmr_r   <= {TW{1'b0}};
            state_r <= ST_LOAD;
          end else begin
            tmr_r <= tmr_r + TW'(1);
          end
        end
        ST_LOAD: begin
          // Write data stalls here with SCLK low and CSN asserted until the source is ready.
          if (!wait_write_s || tx_valid) begin
            mosi_r    <= load_byte_s[7];
            sh_tx_r   <= {load_byte_s[6:0], 1'b0};
            bit_cnt_r <= 3'd0;
            state_r   <= ST_SHIFT;
            if (phase_r == PH_ADDR) addr_r <= addr_r << 8;
          end
        end
        ST_SHIFT: begin
          if (rise_s) begin
            sh_rx_r <= {sh_rx_r[5:0], spi_miso};
            if (last_bit_s && rd_r && (phase_r == PH_DATA)) begin
              rx_data_r  <= {sh_rx_r, spi_miso};
              rx_valid_r <= 1'b1;
            end
          end
          if (fall_s) begin
            mosi_r    <= sh_tx_r[7];
            sh_tx_r   <= {sh_tx_r[6:0], 1'b0};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (last_bit_s) begin
              phase_r <= next_phase_s;
              tmr_r   <= {TW{1'b0}};
              state_r <= end_s ? ST_CS_HOLD : ST_LOAD;
              if (phase_r == PH_ADDR) addr_left_r <= addr_left_r - 8'd1;
              if (phase_r == PH_DATA) len_r <= len_r - LEN_ONE;
            end
          end
        end
        ST_CS_HOLD: begin
          if (tmr_end_s) begin
            tmr_r   <= {TW{1'b0}};
            csn_r   <= 1'b1;
            state_r <= ST_CS_GAP;
          end else begin
            tmr_r <= tmr_r + TW'(1);
          end
        end
        ST_CS_GAP: begin
          if (tmr_end_s) begin
            tmr_r   <= {TW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            tmr_r <= tmr_r + TW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          csn_r   <= 1'b1;
        end
      endcase
    end
  end

  assign tx_ready = (state_r == ST_LOAD) && wait_write_s;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign spi_csn  = csn_r;
  assign spi_mosi = mosi_r;

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench for spi_ram_master with a mode-0 SPI slave model on the pins.
module tb_spi_ram_master;

  localparam int STALL_LEN = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [15:0] len = 16'h0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        busy;
  logic        done;
  logic        spi_csn;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  spi_ram_master #(.c_addr_bits(32), .c_len_bits(16), .c_clk_div(4)) dut (
    .clk(clk), .reset(reset), .start(start), .rd(rd), .addr(addr), .len(len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
    .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  // Slave model and event counters, sampled mid-cycle.
  int         rise_cnt = 0, tx_hs = 0, done_cnt = 0, mosi_n = 0, rx_n = 0;
  int         bitpos = 0, byteidx = 0;
  logic [7:0] sh = 8'h00, cur = 8'h00;
  logic       sclk_q = 1'b0;
  logic [7:0] mosi_log [0:255];
  logic [7:0] rx_log [0:15];
  logic [7:0] resp [0:3];

  always @(negedge clk) begin
    if (spi_csn !== 1'b0) begin
      bitpos  = 0;
      byteidx = 0;
    end else begin
      if (spi_sclk === 1'b1 && sclk_q === 1'b0) begin
        rise_cnt++;
        sh = {sh[6:0], spi_mosi};
        bitpos++;
        if (bitpos == 8) begin
          if (mosi_n < 256) mosi_log[mosi_n] = sh;
          mosi_n++;
          bitpos = 0;
          byteidx++;
        end
      end
      if (spi_sclk === 1'b0 && sclk_q === 1'b1) begin
        if (byteidx >= 6 && byteidx < 10) begin
          cur = resp[byteidx - 6];
          spi_miso = cur[3'(7 - bitpos)];
        end else begin
          spi_miso = 1'b0;
        end
      end
    end
    sclk_q = spi_sclk;
    if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_hs++;
    if (done === 1'b1) done_cnt++;
    if (rx_valid === 1'b1) begin
      if (rx_n < 16) rx_log[rx_n] = rx_data;
      rx_n++;
    end
  end

  int         n_checks = 0, n_fail = 0;
  logic [7:0] tx_mem [0:7];
  int         tx_n = 0, tx_idx = 0, stall_at = -1, stall_left = 0, stall_bad = 0, stall_rise = 0;

  task automatic drive_tx();
    tx_valid = (tx_idx < tx_n) && !(tx_idx == stall_at && stall_left > 0);
    tx_data  = (tx_idx < 8) ? tx_mem[tx_idx] : 8'h00;
  endtask

  task automatic issue(input logic r, input logic [31:0] a, input logic [15:0] l);
    rd = r; addr = a; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs until done is seen (returns mid-cycle of the done cycle) or the budget runs out.
  task automatic run_xfer(input int max_cyc, input int spur_cyc, output bit ok);
    bit took;
    ok = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      took = (tx_valid === 1'b1) && (tx_ready === 1'b1);
      if (tx_ready === 1'b1 && tx_valid === 1'b0 && stall_left > 0) begin
        if (stall_left == STALL_LEN) stall_rise = rise_cnt;
        stall_left--;
        if (spi_sclk !== 1'b0 || spi_csn !== 1'b0 || rise_cnt != stall_rise) stall_bad++;
      end
      @(posedge clk); #1;
      if (took) tx_idx++;
      start = (k == spur_cyc);
      drive_tx();
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (spi_csn !== 1'b1) begin n_fail++; $display("FAIL reset_csn got %b want 1", spi_csn); end
    n_checks++; if (spi_sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got %b want 0", spi_sclk); end
    n_checks++; if (spi_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got %b want 0", spi_mosi); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_tx_ready got %b want 0", tx_ready); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    logic [7:0] exp_b [7] = '{8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'hA5, 8'h3C};
    int b = mosi_n, h = tx_hs, d = done_cnt, r = rise_cnt;
    bit ok;
    tx_mem[0] = 8'hA5; tx_mem[1] = 8'h3C; tx_n = 2; tx_idx = 0; stall_at = -1; stall_left = 0;
    drive_tx();
    issue(1'b0, 32'h0000_1234, 16'd2);
    n_checks++; if (busy !== 1'b1 || spi_csn !== 1'b0) begin n_fail++; $display("FAIL wr_start busy=%b csn=%b want 1/0", busy, spi_csn); end
    run_xfer(3000, -1, ok);
    @(posedge clk); #1;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wr_done_timeout got 0 want 1"); end
    n_checks++; if (mosi_n - b != 7) begin n_fail++; $display("FAIL wr_nbytes got %0d want 7", mosi_n - b); end
    for (int i = 0; i < 7; i++) begin
      n_checks++; if (mosi_log[b + i] !== exp_b[i]) begin n_fail++; $display("FAIL wr_byte%0d got %h want %h", i, mosi_log[b + i], exp_b[i]); end
    end
    n_checks++; if (rise_cnt - r != 56) begin n_fail++; $display("FAIL wr_rises got %0d want 56", rise_cnt - r); end
    n_checks++; if (tx_hs - h != 2) begin n_fail++; $display("FAIL wr_handshakes got %0d want 2", tx_hs - h); end
    n_checks++; if (done_cnt - d != 1) begin n_fail++; $display("FAIL wr_dones got %0d want 1", done_cnt - d); end
    n_checks++; if (busy !== 1'b0 || spi_csn !== 1'b1) begin n_fail++; $display("FAIL wr_idle busy=%b csn=%b want 0/1", busy, spi_csn); end
  endtask

  task automatic test_read();
    logic [7:0] exp_b [6] = '{8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    int b = mosi_n, h = tx_hs, d = done_cnt, x = rx_n;
    bit ok;
    resp[0] = 8'h5A; tx_n = 0; tx_idx = 0;
    drive_tx();
    issue(1'b1, 32'hFF00_0000, 16'd1);
    run_xfer(3000, -1, ok);
    @(posedge clk); #1;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rd_done_timeout got 0 want 1"); end
    n_checks++; if (mosi_n - b != 7) begin n_fail++; $display("FAIL rd_nbytes got %0d want 7", mosi_n - b); end
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (mosi_log[b + i] !== exp_b[i]) begin n_fail++; $display("FAIL rd_byte%0d got %h want %h", i, mosi_log[b + i], exp_b[i]); end
    end
    n_checks++; if (rx_n - x != 1) begin n_fail++; $display("FAIL rd_rx_count got %0d want 1", rx_n - x); end
    n_checks++; if (rx_log[x] !== 8'h5A) begin n_fail++; $display("FAIL rd_rx_data got %h want 5a", rx_log[x]); end
    n_checks++; if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL rd_rx_hold got %h want 5a", rx_data); end
    n_checks++; if (tx_hs - h != 0) begin n_fail++; $display("FAIL rd_handshakes got %0d want 0", tx_hs - h); end
    n_checks++; if (done_cnt - d != 1) begin n_fail++; $display("FAIL rd_dones got %0d want 1", done_cnt - d); end
  endtask

  task automatic test_stall();
    logic [7:0] exp_b [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'hC3, 8'h96};
    int b = mosi_n, h = tx_hs, d = done_cnt;
    bit ok;
    tx_mem[0] = 8'hC3; tx_mem[1] = 8'h96; tx_n = 2; tx_idx = 0;
    stall_at = 1; stall_left = STALL_LEN; stall_bad = 0;
    drive_tx();
    issue(1'b0, 32'h0000_0040, 16'd2);
    run_xfer(4000, -1, ok);
    @(posedge clk); #1;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL st_done_timeout got 0 want 1"); end
    n_checks++; if (stall_left != 0) begin n_fail++; $display("FAIL st_wait_cycles left %0d want 0", stall_left); end
    n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL st_pins_during_wait bad=%0d want 0", stall_bad); end
    n_checks++; if (mosi_n - b != 7) begin n_fail++; $display("FAIL st_nbytes got %0d want 7", mosi_n - b); end
    for (int i = 0; i < 7; i++) begin
      n_checks++; if (mosi_log[b + i] !== exp_b[i]) begin n_fail++; $display("FAIL st_byte%0d got %h want %h", i, mosi_log[b + i], exp_b[i]); end
    end
    n_checks++; if (tx_hs - h != 2) begin n_fail++; $display("FAIL st_handshakes got %0d want 2", tx_hs - h); end
    n_checks++; if (done_cnt - d != 1) begin n_fail++; $display("FAIL st_dones got %0d want 1", done_cnt - d); end
    stall_at = -1;
  endtask

  task automatic test_len0();
    logic [7:0] exp_b [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
    int b = mosi_n, h = tx_hs, d = done_cnt, r = rise_cnt;
    bit ok;
    tx_mem[0] = 8'hEE; tx_n = 1; tx_idx = 0;
    drive_tx();
    issue(1'b0, 32'h0000_0010, 16'd0);
    run_xfer(3000, -1, ok);
    @(posedge clk); #1;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL l0_done_timeout got 0 want 1"); end
    n_checks++; if (mosi_n - b != 5) begin n_fail++; $display("FAIL l0_nbytes got %0d want 5", mosi_n - b); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (mosi_log[b + i] !== exp_b[i]) begin n_fail++; $display("FAIL l0_byte%0d got %h want %h", i, mosi_log[b + i], exp_b[i]); end
    end
    n_checks++; if (rise_cnt - r != 40) begin n_fail++; $display("FAIL l0_rises got %0d want 40", rise_cnt - r); end
    n_checks++; if (tx_hs - h != 0) begin n_fail++; $display("FAIL l0_handshakes got %0d want 0", tx_hs - h); end
    n_checks++; if (done_cnt - d != 1) begin n_fail++; $display("FAIL l0_dones got %0d want 1", done_cnt - d); end
    tx_n = 0; tx_idx = 0;
    drive_tx();
  endtask

  task automatic test_reset_abort();
    int b = mosi_n, d, x;
    bit reached = 1'b0, ok;
    tx_n = 0; tx_idx = 0;
    drive_tx();
    issue(1'b1, 32'hAB00_0000, 16'd3);
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (mosi_n - b >= 2) begin
        reached = 1'b1;
        break;
      end
    end
    n_checks++; if (!reached) begin n_fail++; $display("FAIL ra_reach_addr got 0 want 1"); end
    repeat (20) @(posedge clk);
    @(negedge clk);
    d = done_cnt;
    reset = 1'b1;
    #1;
    n_checks++; if (spi_csn !== 1'b1) begin n_fail++; $display("FAIL ra_csn got %b want 1", spi_csn); end
    n_checks++; if (spi_sclk !== 1'b0) begin n_fail++; $display("FAIL ra_sclk got %b want 0", spi_sclk); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ra_busy got %b want 0", busy); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    n_checks++; if (done_cnt != d) begin n_fail++; $display("FAIL ra_no_done got %0d want %0d", done_cnt, d); end
    resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h33;
    x = rx_n; d = done_cnt; b = mosi_n;
    issue(1'b1, 32'h0000_0100, 16'd3);
    run_xfer(4000, -1, ok);
    @(posedge clk); #1;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ra_read_timeout got 0 want 1"); end
    n_checks++; if (rx_n - x != 3) begin n_fail++; $display("FAIL ra_rx_count got %0d want 3", rx_n - x); end
    n_checks++; if (rx_log[x] !== 8'h11 || rx_log[x + 1] !== 8'h22 || rx_log[x + 2] !== 8'h33) begin
      n_fail++; $display("FAIL ra_rx_data got %h %h %h want 11 22 33", rx_log[x], rx_log[x + 1], rx_log[x + 2]);
    end
    n_checks++; if (mosi_n - b != 9 || mosi_log[b] !== 8'h01) begin n_fail++; $display("FAIL ra_hdr got n=%0d cmd=%h want 9/01", mosi_n - b, mosi_log[b]); end
    n_checks++; if (done_cnt - d != 1) begin n_fail++; $display("FAIL ra_dones got %0d want 1", done_cnt - d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [13] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h77,
                                8'h01, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00};
    int b = mosi_n, d = done_cnt, x = rx_n;
    bit ok;
    tx_mem[0] = 8'h77; tx_n = 1; tx_idx = 0;
    drive_tx();
    issue(1'b0, 32'h0000_0020, 16'd1);
    rd = 1'b1; addr = 32'hDEAD_BEEF; len = 16'd5;
    run_xfer(3000, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bb_first_timeout got 0 want 1"); end
    tx_n = 0; tx_idx = 0; resp[0] = 8'h99;
    drive_tx();
    issue(1'b1, 32'h0000_0030, 16'd1);
    n_checks++; if (busy !== 1'b1 || spi_csn !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL bb_restart busy=%b csn=%b done=%b want 1/0/0", busy, spi_csn, done);
    end
    run_xfer(3000, -1, ok);
    @(posedge clk); #1;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bb_second_timeout got 0 want 1"); end
    n_checks++; if (mosi_n - b != 13) begin n_fail++; $display("FAIL bb_nbytes got %0d want 13", mosi_n - b); end
    for (int i = 0; i < 13; i++) begin
      n_checks++; if (mosi_log[b + i] !== exp_b[i]) begin n_fail++; $display("FAIL bb_byte%0d got %h want %h", i, mosi_log[b + i], exp_b[i]); end
    end
    n_checks++; if (done_cnt - d != 2) begin n_fail++; $display("FAIL bb_dones got %0d want 2", done_cnt - d); end
    n_checks++; if (rx_n - x != 1 || rx_log[x] !== 8'h99) begin n_fail++; $display("FAIL bb_rx got n=%0d d=%h want 1/99", rx_n - x, rx_log[x]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_len0();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
